// File: rtl/rs_flag_bank.sv
// Bank of WIDTH clocked set/reset flags with synchronised hardware requests,
// software set/clear, change pulses and any/all status.
// Optional per-channel rise counters: define RS_FLAG_BANK_CNT_EN.
module rs_flag_bank #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      SET_PRIORITY = 0,
  parameter int unsigned      EDGE_MODE    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_hw_set,
  input  logic [WIDTH-1:0]   i_hw_reset,
  input  logic [WIDTH-1:0]   i_sw_set,
  input  logic [WIDTH-1:0]   i_sw_clr,
  input  logic               i_cnt_clr,
  output logic [WIDTH-1:0]   o_q,
  output logic [WIDTH-1:0]   o_qn,
  output logic [WIDTH-1:0]   o_rise,
  output logic [WIDTH-1:0]   o_fall,
  output logic               o_any,
  output logic               o_all,
  output logic [WIDTH*8-1:0] o_cnt
);

  localparam int unsigned CNT_W = 8;

  logic [WIDTH-1:0] w_hs_sync;
  logic [WIDTH-1:0] w_hr_sync;
  logic [WIDTH-1:0] w_hs_eff;
  logic [WIDTH-1:0] w_hr_eff;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qn;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Synchroniser chain on the asynchronous hardware requests
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_hs_sync = i_hw_set;
      assign w_hr_sync = i_hw_reset;
    end else begin : g_sync
      logic [WIDTH-1:0] r_hs_pipe [SYNC_STAGES];
      logic [WIDTH-1:0] r_hr_pipe [SYNC_STAGES];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
            r_hs_pipe[k] <= '0;
            r_hr_pipe[k] <= '0;
          end
        end else begin
          r_hs_pipe[0] <= i_hw_set;
          r_hr_pipe[0] <= i_hw_reset;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            r_hs_pipe[k] <= r_hs_pipe[k-1];
            r_hr_pipe[k] <= r_hr_pipe[k-1];
          end
        end
      end

      assign w_hs_sync = r_hs_pipe[SYNC_STAGES-1];
      assign w_hr_sync = r_hr_pipe[SYNC_STAGES-1];
    end
  endgenerate

  // Level or rising-edge interpretation of the synchronised requests
  generate
    if (EDGE_MODE == 0) begin : g_level
      assign w_hs_eff = w_hs_sync;
      assign w_hr_eff = w_hr_sync;
    end else begin : g_edge
      localparam int unsigned FILL_W = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);

      logic [FILL_W-1:0] r_fill;
      logic [WIDTH-1:0]  r_hs_prev;
      logic [WIDTH-1:0]  r_hr_prev;

      // History stays all-ones while the synchroniser refills after reset, so
      // a level already present at release never looks like a fresh edge.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_fill    <= FILL_W'(SYNC_STAGES);
          r_hs_prev <= '1;
          r_hr_prev <= '1;
        end else if (r_fill != '0) begin
          r_fill    <= r_fill - FILL_W'(1);
          r_hs_prev <= '1;
          r_hr_prev <= '1;
        end else begin
          r_hs_prev <= w_hs_sync;
          r_hr_prev <= w_hr_sync;
        end
      end

      assign w_hs_eff = w_hs_sync & ~r_hs_prev;
      assign w_hr_eff = w_hr_sync & ~r_hr_prev;
    end
  endgenerate

  // Per-bit next state with configurable conflict resolution
  always_comb begin
    w_s = w_hs_eff | i_sw_set;
    w_r = w_hr_eff | i_sw_clr;
    if (SET_PRIORITY != 0) begin
      w_q_next = w_s | (~w_r & r_q);
    end else begin
      w_q_next = ~w_r & (w_s | r_q);
    end
    w_rise_next = ~r_q & w_q_next;
    w_fall_next = r_q & ~w_q_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= RESET_VAL;
      r_qn   <= ~RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_q    <= w_q_next;
      r_qn   <= ~w_q_next;
      r_rise <= w_rise_next;
      r_fall <= w_fall_next;
    end
  end

  assign o_q    = r_q;
  assign o_qn   = r_qn;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_any  = |r_q;
  assign o_all  = &r_q;

`ifdef RS_FLAG_BANK_CNT_EN
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // Saturating rise counters; clear beats a coincident increment
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (w_rise_next[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cnt_out
      assign o_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end
  endgenerate
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = i_cnt_clr;
  assign o_cnt            = {(WIDTH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_rs_flag_bank.sv
// Directed bench for rs_flag_bank: default, set-priority and edge-mode
// instances share one stimulus stream.
module tb_rs_flag_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  hw_set;
  logic [3:0]  hw_reset;
  logic [3:0]  sw_set;
  logic [3:0]  sw_clr;
  logic        cnt_clr;

  logic [3:0]  q, qn, rise, fall;
  logic        any, all;
  logic [31:0] cnt;

  logic [3:0]  q_p1, rise_p1, fall_p1;
  logic [3:0]  qn_p1_unused;
  logic        any_p1_unused, all_p1_unused;
  logic [31:0] cnt_p1_unused;

  logic [3:0]  q_e, rise_e, fall_e;
  logic [3:0]  qn_e_unused;
  logic        any_e_unused, all_e_unused;
  logic [31:0] cnt_e_unused;

  int total;
  int bad;
  logic [31:0] exp_sat;
  logic [31:0] exp_one;

  rs_flag_bank #(.WIDTH(4), .SYNC_STAGES(2), .SET_PRIORITY(0), .EDGE_MODE(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_hw_set(hw_set), .i_hw_reset(hw_reset),
    .i_sw_set(sw_set), .i_sw_clr(sw_clr), .i_cnt_clr(cnt_clr),
    .o_q(q), .o_qn(qn), .o_rise(rise), .o_fall(fall),
    .o_any(any), .o_all(all), .o_cnt(cnt)
  );

  rs_flag_bank #(.WIDTH(4), .SYNC_STAGES(2), .SET_PRIORITY(1), .EDGE_MODE(0)) u_dut_p1 (
    .i_clk(clk), .i_rst(rst), .i_hw_set(hw_set), .i_hw_reset(hw_reset),
    .i_sw_set(sw_set), .i_sw_clr(sw_clr), .i_cnt_clr(cnt_clr),
    .o_q(q_p1), .o_qn(qn_p1_unused), .o_rise(rise_p1), .o_fall(fall_p1),
    .o_any(any_p1_unused), .o_all(all_p1_unused), .o_cnt(cnt_p1_unused)
  );

  rs_flag_bank #(.WIDTH(4), .SYNC_STAGES(2), .SET_PRIORITY(0), .EDGE_MODE(1)) u_dut_e (
    .i_clk(clk), .i_rst(rst), .i_hw_set(hw_set), .i_hw_reset(hw_reset),
    .i_sw_set(sw_set), .i_sw_clr(sw_clr), .i_cnt_clr(cnt_clr),
    .o_q(q_e), .o_qn(qn_e_unused), .o_rise(rise_e), .o_fall(fall_e),
    .o_any(any_e_unused), .o_all(all_e_unused), .o_cnt(cnt_e_unused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef RS_FLAG_BANK_CNT_EN
    exp_sat = 32'h0000_00FF;
    exp_one = 32'h0000_0001;
`else
    exp_sat = 32'h0;
    exp_one = 32'h0;
`endif

    // Reset held with hw and sw set requests active
    rst = 1'b1; hw_set = 4'hF; hw_reset = 4'h0; sw_set = 4'hF; sw_clr = 4'h0; cnt_clr = 1'b0;
    tick(2);
    chk("rst_q",    32'(q),    32'h0);
    chk("rst_qn",   32'(qn),   32'hF);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_any",  32'(any),  32'h0);
    chk("rst_cnt",  cnt,       32'h0);
    rst = 1'b0; sw_set = 4'h0;
    tick(1); chk("rel_q_e1", 32'(q), 32'h0);
    tick(1); chk("rel_q_e2", 32'(q), 32'h0);
    tick(1);
    chk("rel_q_e3",    32'(q),    32'hF);
    chk("rel_qn_e3",   32'(qn),   32'h0);
    chk("rel_rise_e3", 32'(rise), 32'hF);
    chk("rel_all_e3",  32'(all),  32'h1);
    chk("edge_held_q", 32'(q_e),  32'h0);
    tick(1);
    chk("rel_rise_e4", 32'(rise), 32'h0);
    chk("rel_fall_e4", 32'(fall), 32'h0);
    chk("rel_q_e4",    32'(q),    32'hF);
    chk("edge_held_q2",32'(q_e),  32'h0);

    // Mid-operation reset, then hw latency on channel 1
    rst = 1'b1; hw_set = 4'h0;
    tick(1);
    chk("midrst_q",    32'(q),    32'h0);
    chk("midrst_fall", 32'(fall), 32'h0);
    rst = 1'b0;
    tick(1);
    hw_set = 4'h2;
    tick(1); chk("lat_e0", 32'(q), 32'h0);
    tick(1); chk("lat_e1", 32'(q), 32'h0);
    tick(1);
    chk("lat_e2_q",    32'(q),    32'h2);
    chk("lat_e2_rise", 32'(rise), 32'h2);
    chk("lat_e2_fall", 32'(fall), 32'h0);
    chk("lat_e2_any",  32'(any),  32'h1);
    chk("lat_e2_all",  32'(all),  32'h0);
    tick(1);
    chk("lat_e3_q",    32'(q),    32'h2);
    chk("lat_e3_rise", 32'(rise), 32'h0);
    chk("lat_e3_fall", 32'(fall), 32'h0);

    // Simultaneous sw set and clear on bits 1:0
    hw_set = 4'h0;
    tick(2);
    sw_set = 4'h3; sw_clr = 4'h3;
    tick(1);
    chk("prio0_q",    32'(q),       32'h0);
    chk("prio0_fall", 32'(fall),    32'h2);
    chk("prio1_q",    32'(q_p1),    32'h3);
    chk("prio1_rise", 32'(rise_p1), 32'h1);
    sw_set = 4'h0; sw_clr = 4'h0;
    tick(1);
    chk("prio0_hold", 32'(q),    32'h0);
    chk("prio1_hold", 32'(q_p1), 32'h3);

    // Held hw reset on bit 3 against a sw set pulse
    hw_reset = 4'h8;
    tick(2);
    sw_set = 4'h8;
    tick(1);
    chk("lvl_q",       32'(q),       32'h0);
    chk("lvl_rise",    32'(rise),    32'h0);
    chk("lvl_p1_q",    32'(q_p1),    32'hB);
    chk("lvl_p1_rise", 32'(rise_p1), 32'h8);
    sw_set = 4'h0;
    tick(1);
    chk("lvl_q2",      32'(q),       32'h0);
    chk("lvl_rise2",   32'(rise),    32'h0);
    chk("lvl_fall2",   32'(fall),    32'h0);
    chk("lvl_p1_q2",   32'(q_p1),    32'h3);
    chk("lvl_p1_fall", 32'(fall_p1), 32'h8);
    hw_reset = 4'h0;
    tick(2);

    // Edge mode: held input across reset, toggle, then sw clear while held
    rst = 1'b1; hw_set = 4'h4;
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("edge_rst_held", 32'(q_e), 32'h0);
    hw_set = 4'h0;
    tick(3);
    hw_set = 4'h4;
    tick(2);
    chk("edge_pre", 32'(q_e), 32'h0);
    tick(1);
    chk("edge_q",    32'(q_e),    32'h4);
    chk("edge_rise", 32'(rise_e), 32'h4);
    tick(1);
    chk("edge_q_hold",  32'(q_e),    32'h4);
    chk("edge_rise_1c", 32'(rise_e), 32'h0);
    sw_clr = 4'h4;
    tick(1);
    chk("edge_clr_q",    32'(q_e),    32'h0);
    chk("edge_clr_fall", 32'(fall_e), 32'h4);
    sw_clr = 4'h0;
    tick(3);
    chk("edge_clr_stays", 32'(q_e),    32'h0);
    chk("edge_fall_1c",   32'(fall_e), 32'h0);

    // Counters: clear, saturate, clear-vs-rise
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_cleared", cnt, 32'h0);
    for (int i = 0; i < 300; i++) begin
      sw_set = 4'h1;
      tick(1);
      sw_set = 4'h0; sw_clr = 4'h1;
      tick(1);
      sw_clr = 4'h0;
    end
    chk("cnt_sat",     cnt,       exp_sat);
    chk("cnt_sat_q",   32'(q),    32'h4);
    sw_set = 4'h1; cnt_clr = 1'b1;
    tick(1);
    chk("cnt_clr_win",  cnt,       32'h0);
    chk("cnt_clr_rise", 32'(rise), 32'h1);
    sw_set = 4'h0; cnt_clr = 1'b0; sw_clr = 4'h1;
    tick(1);
    sw_clr = 4'h0; sw_set = 4'h1;
    tick(1);
    sw_set = 4'h0;
    chk("cnt_after_clr", cnt, exp_one);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
